regfile_param: RTL

- Parametrised register file for the MIPS datapath: configurable data width, depth and number of read ports, with one synchronous write port.
- Adds an optional hardwired zero register and optional write-to-read bypass.
- A hardware initialisation sweep runs after reset and on request, so contents are defined without simulation-only initial blocks.
- Drop-in successor for the single-cycle core's register file; multi-read-port configurations serve later pipelined/superscalar cores.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/regfile_init_fsm.sv | 81 ++++++++
 rtl/regfile_param.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS datapath register file.
// Holds default sizes, fill-mode encodings and the sweep FSM state type.
package mips_pkg;

    // Architectural index of the hardwired zero register.
    localparam int REG_ZERO = 0;

    // Default register file geometry.
    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;

    // Fill-value encodings for the initialisation sweep.
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    // Initialisation sweep FSM states.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_init_fsm.sv
// Initialisation sweep controller for the register file.
// Walks every entry after reset or on request and owns the write port meanwhile.
module regfile_init_fsm
    import mips_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int INIT_MODE = INIT_ZERO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_req,
    output logic          busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr,
    output logic [DW-1:0] sweep_data
);

    rf_state_e     state_q;
    rf_state_e     state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic          busy_q;
    logic          busy_d;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Next-state logic: sweep one entry per cycle, leave at the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    // State, sweep counter and busy flag; reset restarts the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Sweep write request toward the array write mux.
    always_comb begin
        sweep_we   = (state_q == ST_INIT);
        sweep_addr = cnt_q;
        if (INIT_MODE == INIT_INDEX) begin
            sweep_data = DW'(cnt_q);
        end else begin
            sweep_data = '0;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised MIPS register file: one write port, NRD combinational reads.
// Optional zero register and write-to-read bypass; contents set by a sweep.
module regfile_param
    import mips_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int NRD       = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = INIT_ZERO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              init_req,
    output logic              busy
);

    logic [DW-1:0] mem_q [DEPTH];

    logic          sweep_we;
    logic [AW-1:0] sweep_addr;
    logic [DW-1:0] sweep_data;

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          wa_is_zero;

    regfile_init_fsm #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_MODE (INIT_MODE)
    ) u_init (
        .clk        (clk),
        .rst        (rst),
        .init_req   (init_req),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .sweep_data (sweep_data)
    );

    assign wa_is_zero = (ZERO_REG != 0) && (wa == AW'(REG_ZERO));

    // Write mux: the sweep owns the port in INIT, user writes in RUN.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (sweep_we) begin
            mem_we = 1'b1;
            mem_wa = sweep_addr;
            mem_wd = sweep_data;
        end else if (we && !wa_is_zero) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; deliberately not reset, the sweep defines it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra_k;
        logic [DW-1:0] rd_k;

        assign ra_k = ra[k*AW +: AW];

        // Read port k: busy blank, zero reg, bypass, then array.
        always_comb begin
            rd_k = mem_q[ra_k];
            if (busy) begin
                rd_k = '0;
            end else if ((ZERO_REG != 0) && (ra_k == AW'(REG_ZERO))) begin
                rd_k = '0;
            end else if ((BYPASS != 0) && we && (ra_k == wa) && !wa_is_zero) begin
                rd_k = wd;
            end
        end

        assign rd[k*DW +: DW] = rd_k;
    end

endmodule
